// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk_in cycles, with a sticky stall flag.
// Optional min/max period tracking is enabled by defining PERIOD_STATS_EN.
module clk_period_meter #(
  parameter int unsigned CNT_W         = 33,
  parameter int unsigned TIMEOUT_VALUE = 200000000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEAS = 1'b1;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_VALUE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s, rise, fall;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] hcap_q, hcap_d;
  logic             fall_seen_q, fall_seen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    hcap_d      = hcap_q;
    fall_seen_d = fall_seen_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;
    if (state_q == IDLE) begin
      cnt_d       = '0;
      hcnt_d      = '0;
      fall_seen_d = 1'b0;
      if (rise) begin
        state_d = MEAS;
        cnt_d   = ONE;
        hcnt_d  = ONE;
      end
    end else begin
      // A rise takes priority over an expiring count so a period of exactly TIMEOUT_VALUE still measures.
      if (rise) begin
        period_d    = cnt_q;
        high_d      = fall_seen_q ? hcap_q : cnt_q;
        valid_d     = 1'b1;
        timeout_d   = 1'b0;
        cnt_d       = ONE;
        hcnt_d      = ONE;
        fall_seen_d = 1'b0;
      end else if (cnt_q == TMO) begin
        timeout_d   = 1'b1;
        state_d     = IDLE;
        cnt_d       = '0;
        hcnt_d      = '0;
        fall_seen_d = 1'b0;
      end else begin
        cnt_d = cnt_q + ONE;
        if (fall) begin
          fall_seen_d = 1'b1;
          hcap_d      = hcnt_q;
        end else if (s && !fall_seen_q) begin
          hcnt_d = hcnt_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      hcap_q      <= '0;
      fall_seen_q <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      hcap_q      <= hcap_d;
      fall_seen_q <= fall_seen_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

`ifdef PERIOD_STATS_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (valid_d) begin
      if (period_d < min_q) min_d = period_d;
      if (period_d > max_q) max_d = period_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`else
  assign min_period = '0;
  assign max_period = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed self-checking bench for clk_period_meter (CNT_W=8, TIMEOUT_VALUE=64, SYNC_STAGES=2).
module tb_clk_period_meter;

`ifdef PERIOD_STATS_EN
  localparam bit         STATS   = 1'b1;
  localparam logic [7:0] MIN_RST = 8'hFF;
`else
  localparam bit         STATS   = 1'b0;
  localparam logic [7:0] MIN_RST = 8'h00;
`endif

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       sig_in = 1'b0;
  logic [7:0] period, high_time, min_period, max_period;
  logic       meas_valid, timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] p;
    logic [7:0] h;
    int         c;
  } ev_t;
  ev_t evq[$];
  bit  to_seen = 1'b0;
  int  to_cyc  = 0;

  clk_period_meter #(
    .CNT_W        (8),
    .TIMEOUT_VALUE(64),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .min_period(min_period),
    .max_period(max_period)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (meas_valid === 1'b1) evq.push_back('{period, high_time, cyc});
    if (timeout === 1'b1 && !to_seen) begin
      to_seen = 1'b1;
      to_cyc  = cyc;
    end
  end

  task automatic drive(input logic v, input int n);
    sig_in = v;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (2) begin
      @(posedge clk_in);
      #1;
    end
    rst = 1'b0;
    evq.delete();
    to_seen = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (period !== 8'd0) begin failures++; $display("FAIL reset_period got %0d exp 0", period); end
    checks++; if (high_time !== 8'd0) begin failures++; $display("FAIL reset_high got %0d exp 0", high_time); end
    checks++; if (meas_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", meas_valid); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    checks++; if (min_period !== MIN_RST) begin failures++; $display("FAIL reset_min got %h exp %h", min_period, MIN_RST); end
    checks++; if (max_period !== 8'd0) begin failures++; $display("FAIL reset_max got %h exp 0", max_period); end
  endtask

  task automatic test_square();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5);
      drive(1'b0, 5);
    end
    drive(1'b0, 6);
    checks++; if (evq.size() !== 4) begin failures++; $display("FAIL sq_count got %0d exp 4", evq.size()); end
    for (int i = 0; i < evq.size(); i++) begin
      checks++; if (evq[i].p !== 8'd10) begin failures++; $display("FAIL sq_period[%0d] got %0d exp 10", i, evq[i].p); end
      checks++; if (evq[i].h !== 8'd5) begin failures++; $display("FAIL sq_high[%0d] got %0d exp 5", i, evq[i].h); end
      if (i > 0) begin
        checks++; if (evq[i].c - evq[i-1].c !== 10) begin failures++; $display("FAIL sq_spacing[%0d] got %0d exp 10", i, evq[i].c - evq[i-1].c); end
      end
    end
    if (STATS) begin
      checks++; if (min_period !== 8'd10 || max_period !== 8'd10) begin failures++; $display("FAIL sq_stats got min %0d max %0d exp 10/10", min_period, max_period); end
    end
  endtask

  task automatic test_duty();
    logic [7:0] exp_h [5];
    exp_h = '{8'd3, 8'd3, 8'd3, 8'd8, 8'd8};
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 3); drive(1'b0, 7); end
    for (int i = 0; i < 3; i++) begin drive(1'b1, 8); drive(1'b0, 2); end
    drive(1'b0, 8);
    checks++; if (evq.size() !== 5) begin failures++; $display("FAIL duty_count got %0d exp 5", evq.size()); end
    for (int i = 0; i < evq.size() && i < 5; i++) begin
      checks++; if (evq[i].p !== 8'd10) begin failures++; $display("FAIL duty_period[%0d] got %0d exp 10", i, evq[i].p); end
      checks++; if (evq[i].h !== exp_h[i]) begin failures++; $display("FAIL duty_high[%0d] got %0d exp %0d", i, evq[i].h, exp_h[i]); end
      if (i > 0) begin
        checks++; if (evq[i].c - evq[i-1].c !== 10) begin failures++; $display("FAIL duty_spacing[%0d] got %0d exp 10", i, evq[i].c - evq[i-1].c); end
      end
    end
  endtask

  task automatic test_min_period();
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1); drive(1'b0, 1); end
    drive(1'b0, 6);
    checks++; if (evq.size() !== 3) begin failures++; $display("FAIL min_count got %0d exp 3", evq.size()); end
    for (int i = 0; i < evq.size(); i++) begin
      checks++; if (evq[i].p !== 8'd2 || evq[i].h !== 8'd1) begin failures++; $display("FAIL min_meas[%0d] got %0d/%0d exp 2/1", i, evq[i].p, evq[i].h); end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    drive(1'b1, 32); drive(1'b0, 32);
    drive(1'b1, 1);  drive(1'b0, 8);
    checks++; if (evq.size() !== 1) begin failures++; $display("FAIL bnd_count got %0d exp 1", evq.size()); end
    if (evq.size() > 0) begin
      checks++; if (evq[0].p !== 8'd64 || evq[0].h !== 8'd32) begin failures++; $display("FAIL bnd_meas got %0d/%0d exp 64/32", evq[0].p, evq[0].h); end
    end
    checks++; if (to_seen !== 1'b0) begin failures++; $display("FAIL bnd_timeout got %b exp 0", to_seen); end
  endtask

  task automatic test_timeout();
    int vcyc;
    do_reset();
    drive(1'b1, 5); drive(1'b0, 5);
    drive(1'b1, 1); drive(1'b0, 80);
    checks++; if (evq.size() !== 1) begin failures++; $display("FAIL to_count got %0d exp 1", evq.size()); end
    vcyc = (evq.size() > 0) ? evq[0].c : 0;
    if (evq.size() > 0) begin
      checks++; if (evq[0].p !== 8'd10) begin failures++; $display("FAIL to_period got %0d exp 10", evq[0].p); end
    end
    checks++; if (!to_seen || to_cyc - vcyc !== 64) begin failures++; $display("FAIL to_delay seen %b got %0d exp 64", to_seen, to_cyc - vcyc); end
    checks++; if (period !== 8'd10) begin failures++; $display("FAIL to_hold got %0d exp 10", period); end
    evq.delete();
    drive(1'b1, 5); drive(1'b0, 5);
    checks++; if (timeout !== 1'b1 || evq.size() !== 0) begin failures++; $display("FAIL to_arm got timeout %b valids %0d exp 1/0", timeout, evq.size()); end
    drive(1'b1, 5); drive(1'b0, 8);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_clear got %b exp 0", timeout); end
    checks++; if (evq.size() !== 1) begin failures++; $display("FAIL to_rearm_count got %0d exp 1", evq.size()); end
    if (evq.size() > 0) begin
      checks++; if (evq[0].p !== 8'd10 || evq[0].h !== 8'd5) begin failures++; $display("FAIL to_rearm_meas got %0d/%0d exp 10/5", evq[0].p, evq[0].h); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(1'b1, 5); drive(1'b0, 5);
    drive(1'b1, 5); drive(1'b0, 25);
    checks++; if (period !== 8'd10) begin failures++; $display("FAIL mr_pre got %0d exp 10", period); end
    rst = 1'b1;
    drive(1'b0, 1);
    checks++; if (period !== 8'd0 || high_time !== 8'd0) begin failures++; $display("FAIL mr_outputs got %0d/%0d exp 0/0", period, high_time); end
    checks++; if (timeout !== 1'b0 || meas_valid !== 1'b0) begin failures++; $display("FAIL mr_flags got %b/%b exp 0/0", timeout, meas_valid); end
    checks++; if (min_period !== MIN_RST || max_period !== 8'd0) begin failures++; $display("FAIL mr_stats got %h/%h exp %h/00", min_period, max_period, MIN_RST); end
    rst = 1'b0;
    evq.delete();
    drive(1'b1, 5); drive(1'b0, 20);
    checks++; if (evq.size() !== 0) begin failures++; $display("FAIL mr_single_rise got %0d valids exp 0", evq.size()); end
  endtask

  task automatic test_stats();
    logic [7:0] exp_p [3];
    exp_p = '{8'd10, 8'd6, 8'd14};
    do_reset();
    drive(1'b1, 5); drive(1'b0, 5);
    drive(1'b1, 3); drive(1'b0, 3);
    drive(1'b1, 7); drive(1'b0, 7);
    drive(1'b1, 1); drive(1'b0, 6);
    checks++; if (evq.size() !== 3) begin failures++; $display("FAIL st_count got %0d exp 3", evq.size()); end
    for (int i = 0; i < evq.size() && i < 3; i++) begin
      checks++; if (evq[i].p !== exp_p[i]) begin failures++; $display("FAIL st_period[%0d] got %0d exp %0d", i, evq[i].p, exp_p[i]); end
    end
    checks++; if (min_period !== (STATS ? 8'd6 : 8'd0)) begin failures++; $display("FAIL st_min got %0d exp %0d", min_period, STATS ? 6 : 0); end
    checks++; if (max_period !== (STATS ? 8'd14 : 8'd0)) begin failures++; $display("FAIL st_max got %0d exp %0d", max_period, STATS ? 14 : 0); end
  endtask

  initial begin
    @(posedge clk_in);
    #1;
    test_reset();
    test_square();
    test_duty();
    test_min_period();
    test_boundary();
    test_timeout();
    test_mid_reset();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
